rv32_branch_core: RTL and testbench
===================================

Name: rv32_branch_core

Overview:
Parameterised multi-cycle RV32 subset core, successor to the fixed-trace branch demo core. Executes a loadable program of ADD/SUB/ADDI/JAL and all six conditional branches, with ECALL as halt. Publishes one architectural trace record per retired instruction on a valid/ready port for the ZKP witness generator, and stalls while the consumer back-pressures.

Parameters:
IMEM_WORDS, 64, instruction memory depth in 32-bit words (power of two, ≥4); AW = clog2(IMEM_WORDS)
NREGS, 32, register count: 32 (RV32I) or 16 (RV32E); any rs1/rs2/rd index ≥ NREGS is illegal
RESET_PC, 0, PC loaded on reset (word aligned)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
imem_we  in  1  program-load write strobe; honoured only in IDLE or HALT
imem_waddr  in  AW  word address
imem_wdata  in  32  instruction word
run  in  1  start execution from IDLE (level, sampled in IDLE only)
busy  out  1  state is FETCH, EXEC or TRACE
halted  out  1  state is HALT
illegal  out  1  sticky; set when HALT is entered due to a fault
trace_valid  out  1  trace record valid
trace_ready  in  1  consumer accepts record
trace_pc  out  32  PC of retired instruction
trace_pc_next  out  32  PC of next instruction
trace_rs1_val  out  32  rs1 operand value read
trace_rs2_val  out  32  rs2 operand value read (0 for I/J-type)
trace_imm  out  32  sign-extended immediate (0 for R-type and ECALL)
trace_is_branch  out  1  conditional branch
trace_taken  out  1  branch taken or JAL
trace_funct3  out  3  instr[14:12]

Behaviour:
- Reset: state IDLE, pc=RESET_PC, all registers 0, illegal=0, trace_valid=0, all trace outputs 0. Imem contents untouched. Reset in any state (including mid-handshake) aborts at that edge; no partial register write survives.
- FSM: IDLE -run-> FETCH -> EXEC -> TRACE -(valid&&ready)-> FETCH, or HALT if instruction was ECALL/illegal. HALT exits only by reset.
- FETCH (1 cycle): ir <= imem[pc[AW+1:2]]. If pc ≥ 4*IMEM_WORDS or pc[1:0]≠0: skip fetch, illegal=1, go HALT directly (no trace record).
- EXEC (1 cycle): decode, read regs (x0 reads 0), compute, write rd (writes to x0 discarded), load trace regs, set trace_valid.
- Decode: opcode 1100011 funct3 000/001/100/101/110/111 = BEQ/BNE/BLT/BGE/BLTU/BGEU (signed vs unsigned compare); B-imm = sext{i[31],i[7],i[30:25],i[11:8],0}. 0010011 funct3 000 = ADDI, I-imm sext i[31:20]. 0110011 funct3 000, funct7 0000000/0100000 = ADD/SUB. 1101111 = JAL, rd=pc+4, J-imm sext{i[31],i[19:12],i[20],i[30:21],0}. 0x00000073 = ECALL. Anything else illegal.
- pc_next: taken branch or JAL -> pc+imm; else pc+4; ECALL/illegal -> pc. Arithmetic mod 2^32.
- Illegal instruction: no register write; record emitted with trace_taken=0, illegal=1 set on record acceptance, then HALT.
- Taken target with bits[1:0]≠0: not faulted in EXEC; faulted by next FETCH (above).
- TRACE: trace outputs stable while trace_valid=1 and trace_ready=0. On handshake: pc<=pc_next, trace_valid=0 next cycle. Min 3 cycles/instruction; no back-to-back valid cycles.
- imem_we while busy: ignored. imem_we while HALT: written, no state change.
- Register file write takes effect at end of EXEC, visible to the next instruction's EXEC.

Test Plan:
- Program ADDI x1,x0,5; ADDI x2,x0,6; BNE x1,x2,+8; (skipped); BEQ x1,x1,+4; ECALL, RESET_PC=0, ready=1 -> records pc 0,4,8,16,20; BNE taken pc_next=16, imm=8; BEQ taken pc_next=20; halted=1, illegal=0.
- Signed/unsigned: x1=-1 (ADDI x1,x0,-1), x2=1; BLT x1,x2,+8 taken; BLTU x1,x2,+8 not taken, pc_next=pc+4, trace_rs1_val=0xFFFFFFFF.
- Back-pressure: hold trace_ready=0 for 5 cycles on the first record -> trace_valid stays 1, all trace fields constant, pc unchanged; release -> pc advances exactly once.
- Faults: opcode 0x0000000F -> one record, illegal=1, halted; JAL to pc 4*IMEM_WORDS -> JAL record then HALT with illegal=1 and no further record; NREGS=16 with ADD x17,... -> illegal.
- x0 and JAL: ADDI x0,x0,7 then ADD x3,x0,x0 -> x3=0; JAL x5,-4 at pc=8 -> x5=12, pc_next=4.
- Reset mid-TRACE with ready=0 -> next cycle trace_valid=0, IDLE, regs zero; imem retained, re-run reproduces identical record stream.

Source files
------------

// File: rtl/rv32_branch_core.sv
// rv32_branch_core
//   Multi-cycle RV32 subset core: ADD/SUB/ADDI/JAL, the six conditional
//   branches, and ECALL as halt. The core publishes one trace record per
//   retired instruction on a valid/ready port and stalls while the consumer
//   holds trace_ready low.
//
//   Ports
//     clk, reset        clock; synchronous active-high reset
//     imem_we/waddr/wdata  program load; accepted only in IDLE or HALT
//     run               starts execution (sampled in IDLE only)
//     busy, halted      status: FETCH/EXEC/TRACE, and HALT
//     illegal           sticky fault flag, set when HALT is entered on a fault
//     trace_*           retired-instruction record, valid/ready handshake
`timescale 1ns/1ps
module rv32_branch_core #(
    parameter int          IMEM_WORDS = 64,
    parameter int          NREGS      = 32,
    parameter logic [31:0] RESET_PC   = 32'h0,
    localparam int         AW         = $clog2(IMEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          imem_we,
    input  logic [AW-1:0] imem_waddr,
    input  logic [31:0]   imem_wdata,
    input  logic          run,
    output logic          busy,
    output logic          halted,
    output logic          illegal,
    output logic          trace_valid,
    input  logic          trace_ready,
    output logic [31:0]   trace_pc,
    output logic [31:0]   trace_pc_next,
    output logic [31:0]   trace_rs1_val,
    output logic [31:0]   trace_rs2_val,
    output logic [31:0]   trace_imm,
    output logic          trace_is_branch,
    output logic          trace_taken,
    output logic [2:0]    trace_funct3
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_TRACE = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // First byte address past the end of instruction memory.
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] rf_q [32];
    logic [31:0] imem [IMEM_WORDS];
    logic        illegal_q;
    logic        halt_pend_q;   // record in flight is ECALL or a fault
    logic        fault_pend_q;  // record in flight is a fault

    logic        trace_valid_q;
    logic [31:0] trace_pc_q, trace_pc_next_q, trace_rs1_q, trace_rs2_q, trace_imm_q;
    logic        trace_br_q, trace_tk_q;
    logic [2:0]  trace_f3_q;

    // ---------------- decode / execute ----------------
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_b, imm_j;
    logic [31:0] a, b;

    logic        legal, ecall, is_br, taken, use1, use2, wr_en;
    logic [31:0] imm, wr_val, rs1_val, rs2_val, pc_next;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];
    assign rd     = ir_q[11:7];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign a      = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign b      = (rs2 == 5'd0) ? '0 : rf_q[rs2];

    function automatic logic reg_ok(input logic [4:0] idx);
        return {27'b0, idx} < NREGS;
    endfunction

    always_comb begin
        legal  = 1'b0;
        ecall  = 1'b0;
        is_br  = 1'b0;
        taken  = 1'b0;
        use1   = 1'b0;
        use2   = 1'b0;
        wr_en  = 1'b0;
        imm    = '0;
        wr_val = '0;
        case (opcode)
            OP_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    legal = 1'b1;
                    is_br = 1'b1;
                    use1  = 1'b1;
                    use2  = 1'b1;
                    imm   = imm_b;
                    case (funct3)
                        3'b000:  taken = (a == b);
                        3'b001:  taken = (a != b);
                        3'b100:  taken = ($signed(a) <  $signed(b));
                        3'b101:  taken = ($signed(a) >= $signed(b));
                        3'b110:  taken = (a <  b);
                        3'b111:  taken = (a >= b);
                        default: taken = 1'b0;
                    endcase
                end
            end
            OP_IMM: begin
                if (funct3 == 3'b000) begin
                    legal  = 1'b1;
                    use1   = 1'b1;
                    imm    = imm_i;
                    wr_en  = 1'b1;
                    wr_val = a + imm_i;
                end
            end
            OP_REG: begin
                if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
                    legal  = 1'b1;
                    use1   = 1'b1;
                    use2   = 1'b1;
                    wr_en  = 1'b1;
                    wr_val = funct7[5] ? (a - b) : (a + b);
                end
            end
            OP_JAL: begin
                legal  = 1'b1;
                taken  = 1'b1;
                imm    = imm_j;
                wr_en  = 1'b1;
                wr_val = pc_q + 32'd4;
            end
            OP_SYSTEM: begin
                if (ir_q == 32'h0000_0073) begin
                    legal = 1'b1;
                    ecall = 1'b1;
                end
            end
            default: legal = 1'b0;
        endcase

        // A register index outside the implemented file makes the whole
        // instruction illegal, so only indices that are actually used count.
        if (legal && ((use1 && !reg_ok(rs1)) || (use2 && !reg_ok(rs2)) ||
                      (wr_en && !reg_ok(rd))))
            legal = 1'b0;

        if (!legal) begin
            is_br = 1'b0;
            taken = 1'b0;
            use1  = 1'b0;
            use2  = 1'b0;
            wr_en = 1'b0;
            imm   = '0;
        end

        rs1_val = use1 ? a : '0;
        rs2_val = use2 ? b : '0;

        if (!legal || ecall)
            pc_next = pc_q;
        else if (taken)
            pc_next = pc_q + imm;
        else
            pc_next = pc_q + 32'd4;
    end

    // ---------------- control ----------------
    logic fetch_fault;
    assign fetch_fault = ({1'b0, pc_q} >= PC_LIMIT) || (pc_q[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (run) state_d = S_FETCH;
            S_FETCH: state_d = fetch_fault ? S_HALT : S_EXEC;
            S_EXEC:  state_d = S_TRACE;
            S_TRACE: if (trace_ready) state_d = halt_pend_q ? S_HALT : S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            pc_q            <= RESET_PC;
            ir_q            <= '0;
            illegal_q       <= 1'b0;
            halt_pend_q     <= 1'b0;
            fault_pend_q    <= 1'b0;
            trace_valid_q   <= 1'b0;
            trace_pc_q      <= '0;
            trace_pc_next_q <= '0;
            trace_rs1_q     <= '0;
            trace_rs2_q     <= '0;
            trace_imm_q     <= '0;
            trace_br_q      <= 1'b0;
            trace_tk_q      <= 1'b0;
            trace_f3_q      <= '0;
            for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_FETCH: begin
                    if (fetch_fault) illegal_q <= 1'b1;
                    else             ir_q      <= imem[pc_q[AW+1:2]];
                end
                S_EXEC: begin
                    if (wr_en && rd != 5'd0) rf_q[rd] <= wr_val;
                    trace_valid_q   <= 1'b1;
                    trace_pc_q      <= pc_q;
                    trace_pc_next_q <= pc_next;
                    trace_rs1_q     <= rs1_val;
                    trace_rs2_q     <= rs2_val;
                    trace_imm_q     <= imm;
                    trace_br_q      <= is_br;
                    trace_tk_q      <= taken;
                    trace_f3_q      <= funct3;
                    halt_pend_q     <= ecall || !legal;
                    fault_pend_q    <= !legal;
                end
                S_TRACE: begin
                    if (trace_ready) begin
                        trace_valid_q <= 1'b0;
                        pc_q          <= trace_pc_next_q;
                        if (fault_pend_q) illegal_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Program memory has no reset so a loaded program survives reset.
    always_ff @(posedge clk) begin
        if (imem_we && (state_q == S_IDLE || state_q == S_HALT))
            imem[imem_waddr] <= imem_wdata;
    end

    assign busy            = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_TRACE);
    assign halted          = (state_q == S_HALT);
    assign illegal         = illegal_q;
    assign trace_valid     = trace_valid_q;
    assign trace_pc        = trace_pc_q;
    assign trace_pc_next   = trace_pc_next_q;
    assign trace_rs1_val   = trace_rs1_q;
    assign trace_rs2_val   = trace_rs2_q;
    assign trace_imm       = trace_imm_q;
    assign trace_is_branch = trace_br_q;
    assign trace_taken     = trace_tk_q;
    assign trace_funct3    = trace_f3_q;

endmodule

// File: tb/tb_rv32_branch_core.sv
`timescale 1ns/1ps
module tb_rv32_branch_core;

    localparam int IMEM_WORDS = 16;
    localparam int NREGS      = 16;
    localparam int AW         = 4;

    logic          clk = 1'b0;
    logic          reset, imem_we, run, trace_ready;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          busy, halted, illegal, trace_valid;
    logic [31:0]   trace_pc, trace_pc_next, trace_rs1_val, trace_rs2_val, trace_imm;
    logic          trace_is_branch, trace_taken;
    logic [2:0]    trace_funct3;

    rv32_branch_core #(.IMEM_WORDS(IMEM_WORDS), .NREGS(NREGS), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .run(run), .busy(busy), .halted(halted), .illegal(illegal),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_pc_next(trace_pc_next),
        .trace_rs1_val(trace_rs1_val), .trace_rs2_val(trace_rs2_val),
        .trace_imm(trace_imm), .trace_is_branch(trace_is_branch),
        .trace_taken(trace_taken), .trace_funct3(trace_funct3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, pc_next, rs1, rs2, imm;
        logic        br, tk;
        logic [2:0]  f3;
    } rec_t;

    rec_t        exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] prog [IMEM_WORDS];

    function automatic rec_t mk(input logic [31:0] pc, nx, r1, r2, im,
                                input logic br, tk, input logic [2:0] f3);
        rec_t r;
        r.pc = pc; r.pc_next = nx; r.rs1 = r1; r.rs2 = r2; r.imm = im;
        r.br = br; r.tk = tk; r.f3 = f3;
        return r;
    endfunction

    function automatic rec_t cur();
        return mk(trace_pc, trace_pc_next, trace_rs1_val, trace_rs2_val, trace_imm,
                  trace_is_branch, trace_taken, trace_funct3);
    endfunction

    // Instruction encoders (stimulus only)
    function automatic logic [31:0] enc_i(input int rd, rs1, imm);
        logic [31:0] v = imm;
        return {v[11:0], 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rd, rs1, rs2);
        return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input int rs1, rs2, imm);
        logic [31:0] v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int rd, imm);
        logic [31:0] v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
    endfunction
    localparam logic [31:0] ECALL = 32'h0000_0073;

    // Monitor: pops the scoreboard on every accepted record.
    logic prev_hs = 1'b0;
    always @(negedge clk) begin : mon
        rec_t e;
        if (prev_hs) begin
            n_assert++;
            if (trace_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL back_to_back_valid: got %b required 0", trace_valid);
            end
        end
        prev_hs = trace_valid && trace_ready && !reset;
        if (trace_valid && trace_ready && !reset) begin
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_record: got pc=%h required no record", trace_pc);
            end else begin
                e = exp_q.pop_front();
                if (cur() !== e) begin
                    n_fail++;
                    $display("FAIL record pc=%h: got %h required %h", e.pc, cur(), e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_rec(input string name, input rec_t act, input rec_t exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < IMEM_WORDS; i++) prog[i] = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; imem_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < IMEM_WORDS; i++) begin
            imem_we = 1'b1; imem_waddr = AW'(i); imem_wdata = prog[i];
            @(posedge clk); #1;
        end
        imem_we = 1'b0;
    endtask

    task automatic start();
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        int k = 0;
        while (!halted && k < 200) begin @(posedge clk); #1; k++; end
        chk(name, 32'(halted), 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!trace_valid && k < 50) begin @(posedge clk); #1; k++; end
        chk(name, 32'(trace_valid), 32'd1);
    endtask

    task automatic finish_check(input string name, input logic exp_ill);
        wait_halt({name, "_halted"});
        chk({name, "_illegal"}, 32'(illegal), 32'(exp_ill));
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic prog_basic();
        clear_prog();
        prog[0] = enc_i(1, 0, 5);
        prog[1] = enc_i(2, 0, 6);
        prog[2] = enc_b(3'b001, 1, 2, 8);
        prog[4] = enc_b(3'b000, 1, 1, 4);
        prog[5] = ECALL;
    endtask

    task automatic push_basic();
        exp_q.push_back(mk(0,  4,  0, 0, 5, 0, 0, 3'd0));
        exp_q.push_back(mk(4,  8,  0, 0, 6, 0, 0, 3'd0));
        exp_q.push_back(mk(8,  16, 5, 6, 8, 1, 1, 3'd1));
        exp_q.push_back(mk(16, 20, 5, 5, 4, 1, 1, 3'd0));
        exp_q.push_back(mk(20, 20, 0, 0, 0, 0, 0, 3'd0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; run = 1'b0; imem_we = 1'b0; imem_waddr = '0;
        imem_wdata = '0; trace_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk_rec("rst_trace", cur(), mk(0, 0, 0, 0, 0, 0, 0, 3'd0));

        // Basic branch program
        prog_basic(); load_prog(); push_basic();
        trace_ready = 1'b1; start();
        finish_check("basic", 1'b0);

        // Signed vs unsigned compares and SUB
        do_reset(); clear_prog();
        prog[0]  = enc_i(1, 0, -1);
        prog[1]  = enc_i(2, 0, 1);
        prog[2]  = enc_b(3'b100, 1, 2, 8);
        prog[4]  = enc_b(3'b110, 1, 2, 8);
        prog[5]  = enc_b(3'b101, 1, 2, 8);
        prog[6]  = enc_b(3'b111, 1, 2, 8);
        prog[8]  = enc_r(7'b0100000, 3, 1, 2);
        prog[9]  = enc_b(3'b001, 3, 1, 8);
        prog[11] = ECALL;
        load_prog();
        exp_q.push_back(mk(0,  4,  0, 0, 32'hFFFFFFFF, 0, 0, 3'd0));
        exp_q.push_back(mk(4,  8,  0, 0, 1, 0, 0, 3'd0));
        exp_q.push_back(mk(8,  16, 32'hFFFFFFFF, 1, 8, 1, 1, 3'd4));
        exp_q.push_back(mk(16, 20, 32'hFFFFFFFF, 1, 8, 1, 0, 3'd6));
        exp_q.push_back(mk(20, 24, 32'hFFFFFFFF, 1, 8, 1, 0, 3'd5));
        exp_q.push_back(mk(24, 32, 32'hFFFFFFFF, 1, 8, 1, 1, 3'd7));
        exp_q.push_back(mk(32, 36, 32'hFFFFFFFF, 1, 0, 0, 0, 3'd0));
        exp_q.push_back(mk(36, 44, 32'hFFFFFFFE, 32'hFFFFFFFF, 8, 1, 1, 3'd1));
        exp_q.push_back(mk(44, 44, 0, 0, 0, 0, 0, 3'd0));
        trace_ready = 1'b1; start();
        finish_check("signed", 1'b0);

        // Back-pressure on first record; an imem write while busy is ignored
        do_reset(); prog_basic(); load_prog();
        trace_ready = 1'b0; start();
        wait_valid("bp_first_valid");
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(trace_valid), 32'd1);
            chk_rec("bp_hold", cur(), mk(0, 4, 0, 0, 5, 0, 0, 3'd0));
            imem_we = (i == 0); imem_waddr = 4'd1; imem_wdata = 32'h0000000F;
            @(posedge clk); #1;
        end
        imem_we = 1'b0;
        push_basic();
        trace_ready = 1'b1;
        finish_check("bp", 1'b0);

        // Illegal opcode: illegal flag rises only on record acceptance
        do_reset(); clear_prog();
        prog[0] = 32'h0000000F;
        load_prog();
        trace_ready = 1'b0; start();
        wait_valid("ill_valid");
        chk("ill_pre_flag", 32'(illegal), 32'd0);
        chk("ill_pre_halted", 32'(halted), 32'd0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'd0));
        trace_ready = 1'b1;
        finish_check("ill_op", 1'b1);

        // JAL past end of memory: record, then fetch fault with no record
        do_reset(); clear_prog();
        prog[0] = enc_i(1, 0, 1);
        prog[1] = enc_j(0, 60);
        load_prog();
        exp_q.push_back(mk(0, 4,  0, 0, 1,  0, 0, 3'd0));
        exp_q.push_back(mk(4, 64, 0, 0, 60, 0, 1, 3'd0));
        trace_ready = 1'b1; start();
        finish_check("jal_oob", 1'b1);

        // Register index beyond RV32E file
        do_reset(); clear_prog();
        prog[0] = enc_r(7'b0000000, 17, 0, 0);
        load_prog();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'd0));
        trace_ready = 1'b1; start();
        finish_check("rv32e_idx", 1'b1);

        // Misaligned taken target faults at the following fetch
        do_reset(); clear_prog();
        prog[0] = enc_b(3'b000, 0, 0, 6);
        load_prog();
        exp_q.push_back(mk(0, 6, 0, 0, 6, 1, 1, 3'd0));
        trace_ready = 1'b1; start();
        finish_check("misalign", 1'b1);

        // x0 writes discarded, JAL link and backward jump
        do_reset(); clear_prog();
        prog[0] = enc_i(0, 0, 7);
        prog[1] = enc_b(3'b001, 5, 0, 12);
        prog[2] = enc_j(5, -4);
        prog[4] = enc_r(7'b0000000, 3, 0, 0);
        prog[5] = enc_r(7'b0000000, 4, 3, 5);
        prog[6] = ECALL;
        load_prog();
        exp_q.push_back(mk(0,  4,  0,  0,  7,  0, 0, 3'd0));
        exp_q.push_back(mk(4,  8,  0,  0,  12, 1, 0, 3'd1));
        exp_q.push_back(mk(8,  4,  0,  0,  32'hFFFFFFFC, 0, 1, 3'd7));
        exp_q.push_back(mk(4,  16, 12, 0,  12, 1, 1, 3'd1));
        exp_q.push_back(mk(16, 20, 0,  0,  0,  0, 0, 3'd0));
        exp_q.push_back(mk(20, 24, 0,  12, 0,  0, 0, 3'd0));
        exp_q.push_back(mk(24, 24, 0,  0,  0,  0, 0, 3'd0));
        trace_ready = 1'b1; start();
        finish_check("x0_jal", 1'b0);

        // Reset mid-TRACE clears registers; imem is retained
        do_reset(); clear_prog();
        prog[0] = enc_r(7'b0000000, 2, 1, 0);
        prog[1] = enc_i(1, 0, 9);
        prog[2] = ECALL;
        load_prog();
        exp_q.push_back(mk(0, 4, 0, 0, 0, 0, 0, 3'd0));
        trace_ready = 1'b1; start();
        wait_valid("mid_first_valid");
        @(posedge clk); #1;
        trace_ready = 1'b0;
        wait_valid("mid_second_valid");
        chk_rec("mid_second_rec", cur(), mk(4, 8, 0, 0, 9, 0, 0, 3'd0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_valid", 32'(trace_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_pc", trace_pc, 32'd0);
        chk("mid_rst_drained", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(mk(0, 4, 0, 0, 0, 0, 0, 3'd0));
        exp_q.push_back(mk(4, 8, 0, 0, 9, 0, 0, 3'd0));
        exp_q.push_back(mk(8, 8, 0, 0, 0, 0, 0, 3'd0));
        trace_ready = 1'b1; start();
        finish_check("rerun", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
